// File: rtl/custom_hls_ctrl_hub_if.sv
// AXI-lite control bus between the system crossbar and custom_hls_ctrl_hub.
// master = crossbar side, slave = register file side.
interface custom_hls_ctrl_hub_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/custom_hls_ctrl_hub.sv
// AXI-lite register file driving ap_ctrl_hs start/done handshakes for NUM_KERNELS HLS cores.
// Define HLS_CTRL_CYCLE_CNT_EN to implement the per-kernel CYCLES counters.
module custom_hls_ctrl_hub #(
    parameter int NUM_KERNELS = 2,
    parameter int NUM_ARGS    = 4,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    custom_hls_ctrl_hub_if.slave                control_axilite,
    output logic [NUM_KERNELS-1:0]              ap_start_o,
    input  logic [NUM_KERNELS-1:0]              ap_ready_i,
    input  logic [NUM_KERNELS-1:0]              ap_done_i,
    input  logic [NUM_KERNELS-1:0]              ap_idle_i,
    output logic [NUM_KERNELS*NUM_ARGS*32-1:0]  args_o,
    output logic                                interrupt_o
);
    localparam int KW = ADDR_WIDTH - 6;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LAUNCH   = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_COMPLETE = 2'd3;

    logic [1:0]                          r_state [NUM_KERNELS];
    logic [NUM_KERNELS-1:0]              r_auto;
    logic [NUM_KERNELS-1:0]              r_done;
    logic [NUM_KERNELS-1:0]              r_ier;
    logic [NUM_KERNELS*NUM_ARGS-1:0][31:0] r_args;

    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic                   w_wr;
    logic                   w_rd;
    logic [KW-1:0]          w_wk;
    logic [KW-1:0]          w_rk;
    logic [3:0]             w_woff;
    logic [3:0]             w_roff;
    logic                   w_wk_ok;
    logic                   w_rk_ok;
    logic [NUM_KERNELS-1:0] w_whit;
    logic [NUM_KERNELS-1:0] w_start;
    logic [31:0]            w_cycles [NUM_KERNELS];
    logic [31:0]            w_rdata;
    logic [1:0]             w_rresp;
    logic                   w_unused_addr_lsbs;

    // Both address channels are accepted combinationally; bvalid/rvalid block the next beat.
    assign w_wr = control_axilite.awvalid & control_axilite.wvalid & ~r_bvalid & ~rst_i;
    assign w_rd = control_axilite.arvalid & ~r_rvalid & ~rst_i;

    assign w_wk    = control_axilite.awaddr[ADDR_WIDTH-1:6];
    assign w_rk    = control_axilite.araddr[ADDR_WIDTH-1:6];
    assign w_woff  = control_axilite.awaddr[5:2];
    assign w_roff  = control_axilite.araddr[5:2];
    assign w_wk_ok = ({1'b0, w_wk} < (KW+1)'(NUM_KERNELS));
    assign w_rk_ok = ({1'b0, w_rk} < (KW+1)'(NUM_KERNELS));

    assign w_unused_addr_lsbs = &{1'b0, control_axilite.awaddr[1:0], control_axilite.araddr[1:0]};

    assign control_axilite.awready = w_wr;
    assign control_axilite.wready  = w_wr;
    assign control_axilite.arready = w_rd;
    assign control_axilite.bvalid  = r_bvalid;
    assign control_axilite.bresp   = r_bresp;
    assign control_axilite.rvalid  = r_rvalid;
    assign control_axilite.rdata   = r_rdata;
    assign control_axilite.rresp   = r_rresp;

    assign args_o      = r_args;
    assign interrupt_o = |(r_done & r_ier);

    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
            w_whit[k]     = w_wr && (w_wk == KW'(k));
            w_start[k]    = w_whit[k] && (w_woff == 4'd0) && control_axilite.wstrb[0]
                            && control_axilite.wdata[0];
            ap_start_o[k] = (r_state[k] == S_LAUNCH);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_KERNELS; k++) r_state[k] <= S_IDLE;
            r_auto <= '0;
            r_done <= '0;
            r_ier  <= '0;
            r_args <= '0;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (w_whit[k] && control_axilite.wstrb[0]) begin
                    if (w_woff == 4'd0) r_auto[k] <= control_axilite.wdata[7];
                    if (w_woff == 4'd1 && control_axilite.wdata[1]) r_done[k] <= 1'b0;
                    if (w_woff == 4'd2) r_ier[k] <= control_axilite.wdata[0];
                end
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (w_whit[k] && (w_woff == 4'(4 + i))) begin
                        for (int b = 0; b < 4; b++) begin
                            if (control_axilite.wstrb[b])
                                r_args[k*NUM_ARGS+i][8*b +: 8] <= control_axilite.wdata[8*b +: 8];
                        end
                    end
                end
                // COMPLETE is placed after the W1C so a coincident completion keeps DONE set.
                case (r_state[k])
                    S_IDLE:     if (w_start[k]) r_state[k] <= S_LAUNCH;
                    S_LAUNCH:   if (ap_ready_i[k]) r_state[k] <= ap_done_i[k] ? S_COMPLETE : S_RUN;
                    S_RUN:      if (ap_done_i[k]) r_state[k] <= S_COMPLETE;
                    S_COMPLETE: begin
                        r_done[k]  <= 1'b1;
                        r_state[k] <= r_auto[k] ? S_LAUNCH : S_IDLE;
                    end
                    default:    r_state[k] <= S_IDLE;
                endcase
            end
        end
    end

`ifdef HLS_CTRL_CYCLE_CNT_EN
    logic [31:0] r_cycles [NUM_KERNELS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_KERNELS; k++) r_cycles[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (r_state[k] == S_IDLE) begin
                    if (w_start[k]) r_cycles[k] <= '0;
                end else if (r_cycles[k] != 32'hFFFF_FFFF) begin
                    r_cycles[k] <= r_cycles[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) w_cycles[k] = r_cycles[k];
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) w_cycles[k] = '0;
    end
`endif

    always_comb begin
        w_rdata = '0;
        w_rresp = 2'b00;
        if (!w_rk_ok) begin
            w_rresp = 2'b10;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (w_rk == KW'(k)) begin
                    case (w_roff)
                        4'd0: w_rdata = {24'd0, r_auto[k], 7'd0};
                        4'd1: w_rdata = {29'd0, ap_idle_i[k], r_done[k], r_state[k] != S_IDLE};
                        4'd2: w_rdata = {31'd0, r_ier[k]};
                        4'd3: w_rdata = w_cycles[k];
                        default: begin
                            for (int i = 0; i < NUM_ARGS; i++)
                                if (w_roff == 4'(4 + i)) w_rdata = r_args[k*NUM_ARGS+i];
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            if (w_wr) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wk_ok ? 2'b00 : 2'b10;
            end else if (control_axilite.bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (control_axilite.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end
endmodule
